// File: rtl/cpu09_bus_adapter_if.sv
// System-bus side of the 6809 bus-cycle adapter.
// The adapter is the master: it presents a latched address/direction/data
// and holds bus_req until the decoder answers with bus_ack.
interface cpu09_bus_adapter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              bus_err;

    modport master (
        output bus_req, bus_addr, bus_rw, bus_wdata, bus_err,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_addr, bus_rw, bus_wdata, bus_err,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/cpu09_bus_adapter.sv
// Bus-cycle adapter between a 6809-class core and the system bus.
// Each core access is stretched by dropping core_ce until the bus acknowledges
// (after a programmable minimum of wait states) or a timeout forces completion.
// A halt request stops the core only between accesses. Interrupt lines are
// synchronised and, per channel, either passed as levels or latched on a
// falling edge until software clears them.
module cpu09_bus_adapter #(
    parameter int                    ADDR_W      = 16,
    parameter int                    DATA_W      = 8,
    parameter int                    WAIT_W      = 4,
    parameter int                    NUM_IRQ     = 3,
    parameter logic [NUM_IRQ-1:0]    EDGE_MASK   = 3'b100,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               core_vma,
    input  logic [ADDR_W-1:0]  core_addr,
    input  logic               core_rw,
    input  logic [DATA_W-1:0]  core_dout,
    output logic [DATA_W-1:0]  core_din,
    output logic               core_ce,
    output logic [NUM_IRQ-1:0] core_irq_n,
    input  logic [NUM_IRQ-1:0] irq_in_n,
    input  logic [NUM_IRQ-1:0] irq_clr,
    input  logic               halt,
    output logic               halt_ack,
    input  logic [WAIT_W-1:0]  wait_cnt,
    cpu09_bus_adapter_if.master bus
);

    // Value of the timeout counter during the last REQ cycle allowed
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [15:0]        to_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rw_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  din_q;
    logic               err_q;
    logic               ack_ok;
    logic               timeout_hit;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_out;
    logic [NUM_IRQ-1:0] sync_prev_q;
    logic [NUM_IRQ-1:0] edge_latch_q;
    logic [NUM_IRQ-1:0] fall;

    // An ack only counts once the minimum wait states have elapsed; an
    // accepted ack in the final cycle beats the timeout.
    assign ack_ok      = (state_q == ST_REQ) && bus.bus_ack && (wait_q == '0);
    assign timeout_hit = (state_q == ST_REQ) && (to_q == TO_LAST);

    assign bus.bus_req   = (state_q == ST_REQ);
    assign bus.bus_addr  = addr_q;
    assign bus.bus_rw    = rw_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_err   = err_q;
    assign core_din      = din_q;

    // State register; reset drops bus_req at once, aborting any bus cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, core clock enable and halt acknowledge; reset freezes the core
    always_comb begin
        state_d  = state_q;
        core_ce  = 1'b0;
        halt_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                core_ce  = !core_vma && !halt;
                halt_ack = halt && !core_vma;
                if (core_vma) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_ok || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                core_ce = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!rst_n) begin
            core_ce  = 1'b0;
            halt_ack = 1'b0;
        end
    end

    // Access latching, wait/timeout counting, read-data capture and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rw_q    <= 1'b1;
            wdata_q <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
            to_q    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (core_vma) begin
                        addr_q  <= core_addr;
                        rw_q    <= core_rw;
                        wdata_q <= core_dout;
                        wait_q  <= wait_cnt;
                        to_q    <= '0;
                    end
                end
                ST_REQ: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                    to_q <= to_q + 16'd1;
                    if (ack_ok) begin
                        if (rw_q) begin
                            din_q <= bus.bus_rdata;
                        end
                    end else if (timeout_hit) begin
                        if (rw_q) begin
                            din_q <= '1;
                        end
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Interrupt synchroniser chain, idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= irq_in_n;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign fall     = sync_prev_q & ~sync_out & EDGE_MASK;

    // Edge latches: a new falling edge wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_prev_q  <= '1;
            edge_latch_q <= '0;
        end else begin
            sync_prev_q  <= sync_out;
            edge_latch_q <= (fall | (edge_latch_q & ~irq_clr)) & EDGE_MASK;
        end
    end

    assign core_irq_n = (EDGE_MASK & ~edge_latch_q) | (~EDGE_MASK & sync_out);

endmodule

// File: doc/cpu09_bus_adapter.md
# cpu09_bus_adapter

Parametrised bus-cycle adapter between a 6809-class CPU core and the system bus. Stretches each core memory access with a clock-enable stall until the bus acknowledges, honours a programmable minimum wait-state count and an ack timeout, and supports a halt handshake. Also synchronises and conditions a vector of active-low interrupt lines (per-channel level or latched-edge mode) before they reach the core. Instantiated once per CPU, between core and address decoder.

## Interface

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- WAIT_W, 4, width of wait-state count input.
- NUM_IRQ, 3, number of interrupt channels (bit0 irq, bit1 firq, bit2 nmi by convention).
- EDGE_MASK, 3'b100, per channel: 1 = falling-edge latched, 0 = level.
- SYNC_STAGES, 2, synchroniser flops per interrupt input (minimum 2).
- TIMEOUT, 255, max REQ cycles before forced completion (1..2^16-1).

Ports:
- clk  in  1  system clock, all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_vma  in  1  core requests a memory cycle.
- core_addr  in  ADDR_W  core address.
- core_rw  in  1  1 = read, 0 = write.
- core_dout  in  DATA_W  core write data.
- core_din  out  DATA_W  read data to core, registered.
- core_ce  out  1  core clock enable; 0 stalls core.
- core_irq_n  out  NUM_IRQ  conditioned active-low interrupts to core.
- irq_in_n  in  NUM_IRQ  raw asynchronous active-low interrupt sources.
- irq_clr  in  NUM_IRQ  one-cycle clear of latched edge interrupts.
- halt  in  1  request to stop core between accesses.
- halt_ack  out  1  core stopped, bus idle.
- wait_cnt  in  WAIT_W  minimum REQ cycles before ack accepted.
- bus_req  out  1  bus cycle active.
- bus_addr  out  ADDR_W  latched address.
- bus_rw  out  1  latched direction.
- bus_wdata  out  DATA_W  latched write data.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- bus_ack  in  1  bus cycle complete.
- bus_err  out  1  one-cycle pulse on timeout.

## Operation

- States: IDLE, REQ, DONE.
- IDLE: core_ce = !core_vma && !halt. If core_vma=1: latch addr/rw/wdata into bus_*, load wait counter from wait_cnt, clear timeout counter, go REQ. core_vma takes priority over halt sampled in same cycle.
- REQ: bus_req=1, core_ce=0. Wait counter decrements to 0 (saturating); bus_ack ignored while counter nonzero. Ack with counter 0: capture bus_rdata into core_din on reads (writes leave core_din unchanged), go DONE. Timeout counter increments each REQ cycle; reaching TIMEOUT without accepted ack: core_din = all ones on reads, bus_err=1 for one cycle, go DONE. Accepted ack in same cycle as timeout wins (no error).
- DONE: bus_req=0, core_ce=1 for exactly one cycle, go IDLE.
- halt_ack = (state==IDLE) && halt && !core_vma. Access in progress always completes before halt takes effect.
- Interrupts: each irq_in_n passes through SYNC_STAGES flops. Level channel: core_irq_n = synchronised value. Edge channel: synchronised 1->0 transition sets latch, core_irq_n = !latch; irq_clr clears it; new edge in same cycle as clear wins (latch stays set).
- bus_addr/bus_rw/bus_wdata hold last latched values outside REQ.

## Timing

- Reset (async, rst_n=0): state IDLE, bus_req 0, bus_addr 0, bus_rw 1, bus_wdata 0, core_din 0, bus_err 0, wait/timeout counters 0, sync flops and edge latches idle (core_irq_n all 1). core_ce = 0 while rst_n=0; halt_ack 0. Reset mid-REQ aborts bus cycle immediately (bus_req falls asynchronously).
- Zero-wait access: vma seen in IDLE at cycle 0, REQ cycle 1 with ack, DONE cycle 2 (core_ce=1). 3 clocks per access; +n per wait state or late ack.
- Interrupt latency: irq_in_n edge to core_irq_n = SYNC_STAGES cycles (level) or SYNC_STAGES+1 (edge).
- bus_ack is single-cycle sampled; ack during DONE/IDLE ignored.

## Test plan

- Zero-wait read: vma=1, addr 0x1234, wait_cnt 0, ack with rdata 0x5A in first REQ cycle -> bus_req high 1 cycle, core_din 0x5A, core_ce pulse on cycle 2.
- Wait states: wait_cnt 3, ack held high from first REQ cycle -> ack accepted on 4th REQ cycle; write of 0xC3 shows bus_rw 0, bus_wdata 0xC3 throughout.
- Timeout: TIMEOUT 8, no ack on read -> after 8 REQ cycles bus_err pulse, core_din 0xFF, core_ce pulse; ack arriving exactly at cycle 8 -> no bus_err.
- Halt: halt asserted mid-REQ -> access completes, then halt_ack=1, core_ce=0 until halt drops; halt and vma together in IDLE -> access first.
- Interrupts: nmi (edge) pulse low 1 cycle -> core_irq_n[2]=0 after 3 cycles, held until irq_clr[2]; irq (level) follows input with 2-cycle delay; edge coinciding with clear keeps latch set.
- Async reset asserted mid-REQ -> bus_req 0 immediately, all outputs at reset values, clean restart on rst_n release.
